// File: rtl/ps2_cmd_scheduler.sv
// ps2_cmd_scheduler: host-to-device PS/2 command sender.
// Queues keyboard-reset (0xFF) and set-LED (0xED, led byte) requests. For each
// byte it inhibits the clock, issues request-to-send, shifts the frame on
// device clock falling edges, checks the ACK bit, then waits for 0xFA.
// Optional feature: define PS2_RETRY_EN to resend a byte on 0xFE (up to
// MAX_RETRY times). Without it, 0xFE counts as a bad response.
module ps2_cmd_scheduler #(
  parameter int CLK_HZ     = 12_000_000,
  parameter int INHIBIT_US = 100,
  parameter int TIMEOUT_US = 15_000,
  parameter int MAX_RETRY  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       req_reset,
  input  logic       req_led,
  input  logic [2:0] led_state,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic       ps2_clk_pulldown,
  output logic       ps2_data_pulldown,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);

`ifdef PS2_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  // 64-bit math: TIMEOUT_US*CLK_HZ overflows 32 bits at real clock rates
  localparam logic [63:0] INH_CYC = 64'(INHIBIT_US) * 64'(CLK_HZ) / 64'd1_000_000;
  localparam logic [63:0] TO_CYC  = 64'(TIMEOUT_US) * 64'(CLK_HZ) / 64'd1_000_000;
  localparam logic [63:0] TMR_MAX = (INH_CYC > TO_CYC) ? INH_CYC : TO_CYC;
  localparam int TW = (TMR_MAX < 64'd2) ? 1 : $clog2(TMR_MAX + 64'd1);
  localparam logic [TW-1:0] INH_LD = TW'((INH_CYC == 64'd0) ? 64'd0 : INH_CYC - 64'd1);
  localparam logic [TW-1:0] TO_LD  = TW'(TO_CYC);
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SHIFT, ACK, RESP, DONE} state_t;

  state_t        state, nxt;
  logic [TW-1:0] tmr, tmr_n, tmr_dec;
  logic [3:0]    ecnt, ecnt_n;
  logic          dpd, dpd_n;
  logic          idx, idx_n;
  logic          cled, cled_n;
  logic [2:0]    led_val, led_n;
  logic [RW-1:0] rty, rty_n;
  logic          err_n;
  logic [1:0]    code_n;
  logic          pend_rst, pend_led, start_rst, start_led;
  logic          clk_m, clk_s, clk_p, dat_m, dat_s, fall, expired;
  logic [7:0]    cur_byte;
  logic          par, last;

  // Two-flop synchronisers for the bus lines plus a delay tap for edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_m <= 1'b1; clk_s <= 1'b1; clk_p <= 1'b1;
      dat_m <= 1'b1; dat_s <= 1'b1;
    end else begin
      clk_m <= ps2_clk;  clk_s <= clk_m; clk_p <= clk_s;
      dat_m <= ps2_data; dat_s <= dat_m;
    end
  end

  assign fall     = clk_p & ~clk_s;
  assign expired  = (tmr == '0);
  assign tmr_dec  = expired ? tmr : tmr - TW'(1);
  assign cur_byte = cled ? (idx ? {5'b0, led_val} : 8'hED) : 8'hFF;
  assign par      = ~^cur_byte;
  assign last     = ~cled | idx;

  // State and datapath registers, plus the request-pending flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE; tmr <= '0; ecnt <= '0; dpd <= 1'b0; idx <= 1'b0;
      cled <= 1'b0; led_val <= '0; rty <= '0; err <= 1'b0; err_code <= '0;
      pend_rst <= 1'b0; pend_led <= 1'b0;
    end else begin
      state <= nxt; tmr <= tmr_n; ecnt <= ecnt_n; dpd <= dpd_n; idx <= idx_n;
      cled <= cled_n; led_val <= led_n; rty <= rty_n; err <= err_n; err_code <= code_n;
      // a new request wins over the clear so back-to-back requests are kept
      pend_rst <= req_reset | (pend_rst & ~start_rst);
      pend_led <= req_led   | (pend_led & ~start_led);
    end
  end

  // Next-state logic: arbitration, frame sequencing, timeout and abort
  always_comb begin
    nxt = state; tmr_n = tmr; ecnt_n = ecnt; dpd_n = dpd; idx_n = idx;
    cled_n = cled; led_n = led_val; rty_n = rty; err_n = 1'b0; code_n = err_code;
    start_rst = 1'b0; start_led = 1'b0;
    case (state)
      IDLE: begin
        if (pend_rst) begin
          start_rst = 1'b1; cled_n = 1'b0; idx_n = 1'b0; rty_n = '0;
          tmr_n = INH_LD; nxt = INHIBIT;
        end else if (pend_led) begin
          start_led = 1'b1; cled_n = 1'b1; led_n = led_state; idx_n = 1'b0; rty_n = '0;
          tmr_n = INH_LD; nxt = INHIBIT;
        end
      end
      INHIBIT: begin
        if (expired) nxt = RTS;
        else tmr_n = tmr_dec;
      end
      RTS: begin
        // start bit is already driven; clock is released on entry to SHIFT
        dpd_n = 1'b1; ecnt_n = '0; tmr_n = TO_LD; nxt = SHIFT;
      end
      SHIFT: begin
        if (fall) begin
          ecnt_n = ecnt + 4'd1;
          tmr_n  = TO_LD;
          if (ecnt < 4'd8)       dpd_n = ~cur_byte[ecnt[2:0]];
          else if (ecnt == 4'd8) dpd_n = ~par;
          else begin dpd_n = 1'b0; nxt = ACK; end
        end else if (expired) begin
          err_n = 1'b1; code_n = 2'd0; dpd_n = 1'b0; nxt = IDLE;
        end else tmr_n = tmr_dec;
      end
      ACK: begin
        if (fall) begin
          if (!dat_s) begin tmr_n = TO_LD; nxt = RESP; end
          else begin err_n = 1'b1; code_n = 2'd1; nxt = IDLE; end
        end else if (expired) begin
          err_n = 1'b1; code_n = 2'd0; nxt = IDLE;
        end else tmr_n = tmr_dec;
      end
      RESP: begin
        if (rx_valid) begin
          if (rx_byte == 8'hFA) begin
            if (last) nxt = DONE;
            else begin idx_n = 1'b1; rty_n = '0; tmr_n = INH_LD; nxt = INHIBIT; end
          end else if (rx_byte == 8'hFE && RETRY_EN && rty < RW'(MAX_RETRY)) begin
            rty_n = rty + RW'(1); tmr_n = INH_LD; nxt = INHIBIT;
          end else if (rx_byte == 8'hFE && RETRY_EN) begin
            err_n = 1'b1; code_n = 2'd3; nxt = IDLE;
          end else begin
            err_n = 1'b1; code_n = 2'd2; nxt = IDLE;
          end
        end else if (expired) begin
          err_n = 1'b1; code_n = 2'd0; nxt = IDLE;
        end else tmr_n = tmr_dec;
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign ps2_clk_pulldown  = (state == INHIBIT) | (state == RTS);
  assign ps2_data_pulldown = (state == RTS) | ((state == SHIFT) & dpd);
  assign busy              = (state != IDLE);
  assign done              = (state == DONE);

endmodule

// File: tb/tb_ps2_cmd_scheduler.sv
// tb_ps2_cmd_scheduler: directed + randomized bench with a PS/2 device model.
// The device clocks frames, reads bits on rising edges, ACKs and answers on
// rx_byte/rx_valid. Expected bytes/parity/outcomes come from a command-level model.
module tb_ps2_cmd_scheduler;
  logic       clk = 1'b0, rst = 1'b1;
  logic       dev_clk = 1'b1, dev_data = 1'b1;
  logic       req_reset = 1'b0, req_led = 1'b0;
  logic [2:0] led_state = 3'b000;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_valid = 1'b0;
  logic       ps2_clk_pulldown, ps2_data_pulldown, busy, done, err;
  logic [1:0] err_code;
  logic       clk_line, data_line;

  int errors = 0, checks = 0;
  int done_cnt = 0, err_cnt = 0;
  logic [1:0] last_code = 2'd0;
  logic       err_pd = 1'b0;
  logic [7:0] bytes_q[$];

  assign clk_line  = dev_clk  & ~ps2_clk_pulldown;
  assign data_line = dev_data & ~ps2_data_pulldown;

  always #5 clk = ~clk;

  ps2_cmd_scheduler #(.CLK_HZ(1_000_000), .INHIBIT_US(20), .TIMEOUT_US(300), .MAX_RETRY(3)) dut (
    .clk(clk), .rst(rst), .ps2_clk(clk_line), .ps2_data(data_line),
    .req_reset(req_reset), .req_led(req_led), .led_state(led_state),
    .rx_byte(rx_byte), .rx_valid(rx_valid),
    .ps2_clk_pulldown(ps2_clk_pulldown), .ps2_data_pulldown(ps2_data_pulldown),
    .busy(busy), .done(done), .err(err), .err_code(err_code));

  // Pulse monitor: counts done/err and captures line/busy state during err
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (err === 1'b1) begin
      err_cnt   <= err_cnt + 1;
      last_code <= err_code;
      err_pd    <= ps2_clk_pulldown | ps2_data_pulldown | busy;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Odd parity bit: 1 when the byte holds an even number of ones
  function automatic logic odd_par(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) if (b[i]) ones++;
    return (ones % 2 == 0);
  endfunction

  task automatic pulse_req(input logic r, input logic l);
    @(posedge clk); #1; req_reset = r; req_led = l;
    @(posedge clk); #1; req_reset = 1'b0; req_led = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] v);
    repeat (3) @(posedge clk); #1;
    rx_byte = v; rx_valid = 1'b1;
    @(posedge clk); #1; rx_valid = 1'b0;
  endtask

  // Device side of one host-to-device frame (11 clocks)
  task automatic dev_frame(input bit ack, output logic [7:0] b, output logic p,
                           output logic stp, output bit ok);
    int n = 0;
    int hl = $urandom_range(6, 9);
    b = 8'h00; p = 1'b0; stp = 1'b0; ok = 1'b0;
    while (!(ps2_data_pulldown === 1'b1 && ps2_clk_pulldown === 1'b0) && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 3000) return;
    ok = 1'b1;
    repeat (3) @(posedge clk); #1;
    for (int i = 1; i <= 11; i++) begin
      if (i == 11 && ack) dev_data = 1'b0;
      dev_clk = 1'b0;
      repeat (hl) @(posedge clk); #1;
      dev_clk = 1'b1;
      if (i <= 8) b[i-1] = data_line;
      else if (i == 9) p = data_line;
      else if (i == 10) stp = data_line;
      repeat (hl) @(posedge clk); #1;
      dev_data = 1'b1;
    end
  endtask

  task automatic serve(input logic [7:0] exp_b, input logic [7:0] resp, input string tag);
    logic [7:0] b; logic p, s; bit ok;
    dev_frame(1'b1, b, p, s, ok);
    chk({tag, "_frame"}, 32'(ok), 32'd1);
    chk({tag, "_byte"}, 32'(b), 32'(exp_b));
    chk({tag, "_par"}, 32'(p), 32'(odd_par(exp_b)));
    chk({tag, "_stop"}, 32'(s), 32'd1);
    send_rx(resp);
  endtask

  task automatic wait_evt(input int td, input int te, input string tag);
    int n = 0;
    while ((done_cnt < td || err_cnt < te) && n < 3000) begin @(negedge clk); n++; end
    chk({tag, "_wait"}, 32'(n < 3000), 32'd1);
    repeat (2) @(negedge clk);
    chk({tag, "_done"}, done_cnt, td);
    chk({tag, "_err"}, err_cnt, te);
  endtask

  initial begin
    int d0, e0, n, nb, bad_at;
    bit is_led, bad;
    logic [2:0] lv;
    logic [7:0] r;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_clkpd", ps2_clk_pulldown, 0);
    chk("rst_datpd", ps2_data_pulldown, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_code", err_code, 0);
    @(posedge clk); #1; rst = 1'b0;

    // keyboard reset command, measuring the inhibit hold
    d0 = done_cnt; e0 = err_cnt;
    pulse_req(1'b1, 1'b0);
    n = 0;
    while (ps2_clk_pulldown !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    n = 0;
    while (ps2_clk_pulldown === 1'b1 && ps2_data_pulldown === 1'b0 && n < 1000) begin
      @(negedge clk); n++;
    end
    chk("inhibit_cycles", n, 20);
    serve(8'hFF, 8'hFA, "cmd_rst");
    wait_evt(d0 + 1, e0, "cmd_rst");
    chk("cmd_rst_busy", busy, 0);

    // LED update 101
    d0 = done_cnt; e0 = err_cnt;
    led_state = 3'b101;
    pulse_req(1'b0, 1'b1);
    serve(8'hED, 8'hFA, "led_cmd");
    serve(8'h05, 8'hFA, "led_val");
    wait_evt(d0 + 1, e0, "led");
    chk("led_busy", busy, 0);

    // simultaneous requests: reset first, then LED
    d0 = done_cnt; e0 = err_cnt;
    led_state = 3'b010;
    pulse_req(1'b1, 1'b1);
    serve(8'hFF, 8'hFA, "both_rst");
    serve(8'hED, 8'hFA, "both_led");
    serve(8'h02, 8'hFA, "both_val");
    wait_evt(d0 + 2, e0, "both");
    chk("both_busy", busy, 0);

    // rx_valid while idle must be ignored
    d0 = done_cnt; e0 = err_cnt;
    send_rx(8'hAA);
    repeat (20) @(negedge clk);
    chk("idle_rx_busy", busy, 0);
    chk("idle_rx_done", done_cnt, d0);
    chk("idle_rx_err", err_cnt, e0);

    // device never clocks: timeout
    d0 = done_cnt; e0 = err_cnt;
    pulse_req(1'b1, 1'b0);
    wait_evt(d0, e0 + 1, "timeout");
    chk("timeout_code", last_code, 0);
    chk("timeout_lines", err_pd, 0);
    chk("timeout_busy", busy, 0);

    // no ACK bit, then a good command must leave err_code held
    begin
      logic [7:0] b; logic p, s; bit ok;
      d0 = done_cnt; e0 = err_cnt;
      pulse_req(1'b1, 1'b0);
      dev_frame(1'b0, b, p, s, ok);
      chk("noack_byte", 32'(b), 32'hFF);
      wait_evt(d0, e0 + 1, "noack");
      chk("noack_code", last_code, 1);
      chk("noack_lines", err_pd, 0);
    end
    d0 = done_cnt; e0 = err_cnt;
    led_state = 3'b111;
    pulse_req(1'b0, 1'b1);
    serve(8'hED, 8'hFA, "hold_cmd");
    serve(8'h07, 8'hFA, "hold_val");
    wait_evt(d0 + 1, e0, "hold");
    chk("hold_code", err_code, 1);

    // bad response byte
    d0 = done_cnt; e0 = err_cnt;
    pulse_req(1'b1, 1'b0);
    serve(8'hFF, 8'h12, "badresp");
    wait_evt(d0, e0 + 1, "badresp");
    chk("badresp_code", last_code, 2);

    // resend requests
    d0 = done_cnt; e0 = err_cnt;
    pulse_req(1'b1, 1'b0);
`ifdef PS2_RETRY_EN
    serve(8'hFF, 8'hFE, "retry1");
    serve(8'hFF, 8'hFE, "retry2");
    serve(8'hFF, 8'hFA, "retry3");
    wait_evt(d0 + 1, e0, "retry");
`else
    serve(8'hFF, 8'hFE, "resend");
    wait_evt(d0, e0 + 1, "resend");
    chk("resend_code", last_code, 2);
`endif

    // randomized commands against the command-level model
    for (int k = 0; k < 6; k++) begin
      is_led = 1'($urandom_range(0, 1));
      lv     = 3'($urandom);
      bad    = ($urandom_range(0, 3) == 0);
      bytes_q.delete();
      if (is_led) begin bytes_q.push_back(8'hED); bytes_q.push_back({5'b0, lv}); end
      else bytes_q.push_back(8'hFF);
      nb = bytes_q.size();
      bad_at = $urandom_range(0, nb - 1);
      r = 8'($urandom);
      if (r == 8'hFA || r == 8'hFE) r = 8'h00;
      d0 = done_cnt; e0 = err_cnt;
      led_state = lv;
      pulse_req(!is_led, is_led);
      for (int j = 0; j < nb; j++) begin
        if (bad && j == bad_at) begin serve(bytes_q[j], r, "rand_bad"); break; end
        serve(bytes_q[j], 8'hFA, "rand");
      end
      wait_evt(d0 + (bad ? 0 : 1), e0 + (bad ? 1 : 0), "rand");
      if (bad) chk("rand_code", last_code, 2);
    end

    // async reset mid-frame, with an LED request pending
    d0 = done_cnt; e0 = err_cnt;
    pulse_req(1'b1, 1'b0);
    pulse_req(1'b0, 1'b1);
    n = 0;
    while (!(ps2_data_pulldown === 1'b1 && ps2_clk_pulldown === 1'b0) && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    chk("midrst_shift_seen", 32'(n < 3000), 32'd1);
    for (int i = 0; i < 4; i++) begin
      dev_clk = 1'b0; repeat (7) @(posedge clk); #1;
      dev_clk = 1'b1; repeat (7) @(posedge clk); #1;
    end
    chk("midrst_busy_before", busy, 1);
    rst = 1'b1; #1;
    chk("midrst_clkpd", ps2_clk_pulldown, 0);
    chk("midrst_datpd", ps2_data_pulldown, 0);
    chk("midrst_busy", busy, 0);
    repeat (2) @(posedge clk); #1; rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("midrst_pend_cleared", busy, 0);
    chk("midrst_done", done_cnt, d0);
    chk("midrst_err", err_cnt, e0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
